mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 120 ++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with a final sign-fix cycle.
module mult_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_data,
  input  logic [XLEN-1:0] rt_data,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy,
  output logic            done
);
  // Handshake: start is sampled only while idle (busy=0); busy stays high from the
  // accepting edge until the result lands, and done pulses for the one cycle in which
  // hi/lo first show the new result. Nothing is queued.
  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              is_div;
  logic              neg_lo;
  logic              neg_hi;
  logic [XLEN-1:0]   m;
  logic [2*XLEN-1:0] p;

  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_next;
  logic [XLEN:0]     div_shift;
  logic              div_ok;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] div_next;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  always_comb begin
    a_neg = ~op[0] & rs_data[XLEN-1];
    b_neg = ~op[0] & rt_data[XLEN-1];
    a_mag = a_neg ? -rs_data : rs_data;
    b_mag = b_neg ? -rt_data : rt_data;
  end

  // p holds {accumulator, multiplier} for multiply and {remainder, dividend/quotient}
  // for divide; m holds the multiplicand or the divisor magnitude.
  always_comb begin
    mul_sum   = {1'b0, p[2*XLEN-1:XLEN]} + (p[0] ? {1'b0, m} : '0);
    mul_next  = {mul_sum, p[XLEN-1:1]};
    div_shift = {p[2*XLEN-1:XLEN], p[XLEN-1]};
    div_ok    = div_shift >= {1'b0, m};
    div_sub   = div_shift[XLEN-1:0] - m;
    div_next  = {(div_ok ? div_sub : div_shift[XLEN-1:0]), p[XLEN-2:0], div_ok};
    prod_fix  = neg_lo ? -p : p;
    quo_fix   = neg_lo ? -p[XLEN-1:0] : p[XLEN-1:0];
    rem_fix   = neg_hi ? -p[2*XLEN-1:XLEN] : p[2*XLEN-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      m      <= '0;
      p      <= '0;
      hi     <= '0;
      lo     <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            state  <= CALC;
            busy   <= 1'b1;
            cnt    <= '0;
            is_div <= op[1];
            // A zero divisor keeps the all-ones quotient unsigned.
            neg_lo <= (a_neg ^ b_neg) & ~(op[1] && rt_data == '0);
            neg_hi <= a_neg;
            m      <= op[1] ? b_mag : a_mag;
            p      <= {{XLEN{1'b0}}, (op[1] ? a_mag : b_mag)};
          end
        end
        CALC: begin
          p <= is_div ? div_next : mul_next;
          if (cnt == CW'(XLEN - 1)) state <= FIX;
          else                      cnt   <= cnt + 1'b1;
        end
        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*XLEN-1:XLEN];
            lo <= prod_fix[XLEN-1:0];
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
